// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 display path.
//   loader_state_t : frame loader FSM states
//   pixel_t        : packed {r,g,b} pixel, pixel_bpp bits per channel
//   addr_width()   : linear pixel index width for an h x v panel
package hub75_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PEND_SWAP
    } loader_state_t;

    localparam int unsigned pixel_bpp = 8;

    typedef struct packed {
        logic [pixel_bpp-1:0] r;
        logic [pixel_bpp-1:0] g;
        logic [pixel_bpp-1:0] b;
    } pixel_t;

    function automatic int unsigned addr_width(input int unsigned h, input int unsigned v);
        return $clog2(h * v);
    endfunction

endpackage

// File: rtl/hub75_frame_loader.sv
// HUB75 frame loader: writes a raster pixel stream into the back half of a
// ping-pong framebuffer and swaps banks at the next display frame boundary.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_enable                 loader enable
//   s_valid/s_ready/s_data   pixel stream handshake and {R,G,B} payload
//   s_sof/s_eol              start-of-frame / end-of-line markers
//   o_wr_addr/data/en        framebuffer write port, addr = {bank, index}
//   i_disp_frame_end         end-of-displayed-frame pulse from display control
//   o_disp_bank              bank currently shown by the display
//   o_frame_done             one-cycle pulse on a bank swap
//   o_err_count              saturating stream framing error count
module hub75_frame_loader
    import hub75_pkg::*;
#(
    parameter int unsigned hpixel_p = 64,
    parameter int unsigned vpixel_p = 64,
    parameter int unsigned bpp_p    = 8,
    parameter int unsigned err_wd_p = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_enable,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    input  logic [3*bpp_p-1:0]                          s_data,
    input  logic                                        s_sof,
    input  logic                                        s_eol,
    output logic [addr_width(hpixel_p, vpixel_p):0]     o_wr_addr,
    output logic [3*bpp_p-1:0]                          o_wr_data,
    output logic                                        o_wr_en,
    input  logic                                        i_disp_frame_end,
    output logic                                        o_disp_bank,
    output logic                                        o_frame_done,
    output logic [err_wd_p-1:0]                         o_err_count
);

    localparam int unsigned addr_width_p = addr_width(hpixel_p, vpixel_p);
    localparam int unsigned x_wd = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
    localparam int unsigned y_wd = (vpixel_p > 1) ? $clog2(vpixel_p) : 1;
    localparam logic [x_wd-1:0]         x_last    = x_wd'(hpixel_p - 1);
    localparam logic [y_wd-1:0]         y_last    = y_wd'(vpixel_p - 1);
    localparam logic [addr_width_p-1:0] line_step = addr_width_p'(hpixel_p);
    localparam logic [err_wd_p-1:0]     err_max   = '1;

    loader_state_t             state;
    logic [x_wd-1:0]           x;
    logic [y_wd-1:0]           y;
    logic [addr_width_p-1:0]   idx;
    logic [addr_width_p-1:0]   line_start;
    logic                      drop;

    logic                      accept;
    logic                      do_write;
    logic [addr_width_p-1:0]   write_idx;
    logic                      to_pend;

    assign accept = s_valid & s_ready;

    function automatic logic [err_wd_p-1:0] sat_inc(input logic [err_wd_p-1:0] v);
        return (v == err_max) ? v : v + err_wd_p'(1);
    endfunction

    // Decide whether the beat accepted this cycle is written, and where.
    always_comb begin
        do_write  = 1'b0;
        write_idx = idx;
        to_pend   = 1'b0;
        if (accept && i_enable) begin
            if ((state == IDLE || state == LOAD) && s_sof) begin
                do_write  = 1'b1;
                write_idx = '0;
            end else if (state == LOAD && !drop) begin
                do_write = 1'b1;
                to_pend  = (x == x_last) && (y == y_last);
            end
        end
    end

    // Loader FSM, counters and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            idx          <= '0;
            line_start   <= '0;
            drop         <= 1'b0;
            s_ready      <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_disp_bank  <= 1'b0;
            o_frame_done <= 1'b0;
            o_err_count  <= '0;
        end else begin
            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;

            if (do_write) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= {~o_disp_bank, write_idx};
                o_wr_data <= s_data;
            end

            // Ready drops the cycle after the last pixel and while a swap is pending.
            s_ready <= i_enable && !to_pend && !(state == PEND_SWAP && !i_disp_frame_end);

            unique case (state)
                IDLE: begin
                    if (accept && i_enable && s_sof) begin
                        state      <= LOAD;
                        x          <= x_wd'(1);
                        y          <= '0;
                        idx        <= addr_width_p'(1);
                        line_start <= '0;
                        drop       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!i_enable) begin
                        state <= IDLE;
                    end else if (accept) begin
                        if (s_sof) begin
                            o_err_count <= sat_inc(o_err_count);
                            x           <= x_wd'(1);
                            y           <= '0;
                            idx         <= addr_width_p'(1);
                            line_start  <= '0;
                            drop        <= 1'b0;
                        end else if (drop) begin
                            // Overlong line: discard up to and including its eol beat.
                            if (s_eol) begin
                                drop <= 1'b0;
                            end
                        end else if (to_pend) begin
                            if (!s_eol) begin
                                o_err_count <= sat_inc(o_err_count);
                            end
                            state <= PEND_SWAP;
                        end else if (s_eol || x == x_last) begin
                            // Line ends here, early (short), on time, or late (long).
                            if (!(s_eol && x == x_last)) begin
                                o_err_count <= sat_inc(o_err_count);
                            end
                            drop       <= !s_eol;
                            x          <= '0;
                            y          <= y + y_wd'(1);
                            idx        <= line_start + line_step;
                            line_start <= line_start + line_step;
                        end else begin
                            x   <= x + x_wd'(1);
                            idx <= idx + addr_width_p'(1);
                        end
                    end
                end
                PEND_SWAP: begin
                    if (i_disp_frame_end) begin
                        o_disp_bank  <= ~o_disp_bank;
                        o_frame_done <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_frame_loader.sv
// Self-checking bench for hub75_frame_loader on a 4x2 panel.
module tb_hub75_frame_loader;

    localparam int H = 4;
    localparam int V = 2;
    localparam int FS = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_eol = 1'b0;
    logic [3:0]  o_wr_addr;
    logic [23:0] o_wr_data;
    logic        o_wr_en;
    logic        i_disp_frame_end = 1'b0;
    logic        o_disp_bank;
    logic        o_frame_done;
    logic [7:0]  o_err_count;

    hub75_frame_loader #(
        .hpixel_p(H), .vpixel_p(V), .bpp_p(8), .err_wd_p(8)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
        .i_disp_frame_end(i_disp_frame_end), .o_disp_bank(o_disp_bank),
        .o_frame_done(o_frame_done), .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;
    logic [3:0]  wa[$];
    logic [23:0] wd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame position (px,py) with address = bank offset + py*H + px.
    int          m_phase = 0;   // 0 waiting for sof, 1 loading, 2 frame complete
    int          m_px = 0, m_py = 0, m_err = 0;
    bit          m_drop = 0, m_bank = 0;
    bit          e_ready = 0, e_wr_en = 0, e_done = 0;
    logic [3:0]  e_addr = '0;
    logic [23:0] e_data = '0;

    always @(posedge clk) begin : model
        bit acc;
        int pos;
        if (rst) begin
            m_phase = 0; m_px = 0; m_py = 0; m_err = 0; m_drop = 0; m_bank = 0;
            e_ready = 0; e_wr_en = 0; e_done = 0; e_addr = '0; e_data = '0;
        end else begin
            acc = s_valid && e_ready;
            e_wr_en = 0;
            e_done = 0;
            pos = -1;
            if (m_phase == 0) begin
                if (acc && i_enable && s_sof) begin
                    pos = 0; m_px = 1; m_py = 0; m_drop = 0; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (!i_enable) m_phase = 0;
                else if (acc) begin
                    if (s_sof) begin
                        if (m_err < 255) m_err++;
                        pos = 0; m_px = 1; m_py = 0; m_drop = 0;
                    end else if (m_drop) begin
                        if (s_eol) m_drop = 0;
                    end else begin
                        pos = m_py * H + m_px;
                        if (m_px == H - 1 && m_py == V - 1) begin
                            if (!s_eol && m_err < 255) m_err++;
                            m_phase = 2;
                        end else if (s_eol) begin
                            if (m_px != H - 1 && m_err < 255) m_err++;
                            m_px = 0; m_py++;
                        end else if (m_px == H - 1) begin
                            if (m_err < 255) m_err++;
                            m_drop = 1; m_px = 0; m_py++;
                        end else m_px++;
                    end
                end
            end else begin
                if (i_disp_frame_end) begin
                    m_bank = !m_bank; e_done = 1; m_phase = 0;
                end
            end
            if (pos >= 0) begin
                e_wr_en = 1;
                e_addr = 4'((m_bank ? 0 : FS) + pos);
                e_data = s_data;
            end
            e_ready = i_enable && (m_phase != 2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready", 32'(s_ready), 32'(e_ready));
            chk("wr_en", 32'(o_wr_en), 32'(e_wr_en));
            if (e_wr_en) begin
                chk("wr_addr", 32'(o_wr_addr), 32'(e_addr));
                chk("wr_data", 32'(o_wr_data), 32'(e_data));
            end
            chk("disp_bank", 32'(o_disp_bank), 32'(m_bank));
            chk("frame_done", 32'(o_frame_done), 32'(e_done));
            chk("err_count", 32'(o_err_count), 32'(m_err));
            if (o_wr_en === 1'b1) begin
                wa.push_back(o_wr_addr);
                wd.push_back(o_wr_data);
            end
            if (o_frame_done === 1'b1) done_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [23:0] d, input logic sof, input logic eol, input logic fe);
        int n;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s_ready === 1'b1) break;
        end
        if (n == 50) begin
            tests++; fails++;
            $display("FAIL beat_timeout: s_ready stayed 0, expected 1 (t=%0t)", $time);
        end
        i_disp_frame_end = fe;
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; i_disp_frame_end = 1'b0;
    endtask

    task automatic frame(input logic [23:0] base, input logic last_fe);
        for (int i = 0; i < FS; i++)
            beat(base + 24'(i), i == 0, (i % H) == H - 1, last_fe && (i == FS - 1));
    endtask

    task automatic pulse_fe();
        i_disp_frame_end = 1'b1;
        @(posedge clk);
        #1;
        i_disp_frame_end = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_enable = 1'b0;
        idle(2);
        rst = 1'b0;
        wa.delete(); wd.delete(); done_cnt = 0;
    endtask

    task automatic chk_w(input string name, input int i, input logic [3:0] a, input logic [23:0] d);
        chk({name, "_addr"}, 32'(wa[i]), 32'(a));
        chk({name, "_data"}, 32'(wd[i]), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        // Reset values
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_wr_en", 32'(o_wr_en), 32'd0);
        chk("rst_bank", 32'(o_disp_bank), 32'd0);
        chk("rst_err", 32'(o_err_count), 32'd0);
        rst = 1'b0;

        // 1: full frame into bank 1, swap, next frame into bank 0
        i_enable = 1'b1; idle(1);
        frame(24'h000001, 1'b0);
        idle(2);
        chk("t1_ready_pend", 32'(s_ready), 32'd0);
        chk("t1_nwr", 32'(wa.size()), 32'd8);
        for (int i = 0; i < FS; i++) chk_w("t1_w", i, 4'(8 + i), 24'(1 + i));
        pulse_fe(); idle(1);
        chk("t1_bank", 32'(o_disp_bank), 32'd1);
        chk("t1_done", 32'(done_cnt), 32'd1);
        wa.delete(); wd.delete();
        frame(24'h000010, 1'b1);   // frame end coincides with last pixel: no swap yet
        idle(2);
        chk("t1_noswap", 32'(done_cnt), 32'd1);
        chk("t1_bank_hold", 32'(o_disp_bank), 32'd1);
        for (int i = 0; i < FS; i++) chk_w("t1_w2", i, 4'(i), 24'(16 + i));
        pulse_fe(); idle(1);
        chk("t1_bank2", 32'(o_disp_bank), 32'd0);
        chk("t1_done2", 32'(done_cnt), 32'd2);

        // 2: beats without sof in IDLE are dropped
        wa.delete(); wd.delete();
        beat(24'hAA0001, 1'b0, 1'b0, 1'b0);
        beat(24'hAA0002, 1'b0, 1'b0, 1'b0);
        beat(24'hAA0003, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t2_nwr", 32'(wa.size()), 32'd0);
        chk("t2_err", 32'(o_err_count), 32'd0);

        // 3: short line
        do_reset(); i_enable = 1'b1; idle(1);
        beat(24'h21, 1'b1, 1'b0, 1'b0);
        beat(24'h22, 1'b0, 1'b0, 1'b0);
        beat(24'h23, 1'b0, 1'b1, 1'b0);
        beat(24'h24, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("t3_nwr", 32'(wa.size()), 32'd4);
        chk_w("t3_w0", 0, 4'd8, 24'h21);
        chk_w("t3_w2", 2, 4'd10, 24'h23);
        chk_w("t3_w3", 3, 4'd12, 24'h24);
        chk("t3_err", 32'(o_err_count), 32'd1);

        // 4: long line
        do_reset(); i_enable = 1'b1; idle(1);
        for (int i = 0; i < 6; i++) beat(24'h31 + 24'(i), i == 0, i == 5, 1'b0);
        beat(24'h37, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("t4_nwr", 32'(wa.size()), 32'd5);
        chk_w("t4_w3", 3, 4'd11, 24'h34);
        chk_w("t4_w4", 4, 4'd12, 24'h37);
        chk("t4_err", 32'(o_err_count), 32'd1);

        // 5: sof mid-frame restarts, frame then completes
        do_reset(); i_enable = 1'b1; idle(1);
        beat(24'h41, 1'b1, 1'b0, 1'b0);
        beat(24'h42, 1'b0, 1'b0, 1'b0);
        beat(24'h43, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < FS; i++) beat(24'h43 + 24'(i), 1'b0, (i % H) == H - 1, 1'b0);
        idle(2);
        chk("t5_nwr", 32'(wa.size()), 32'd10);
        chk_w("t5_restart", 2, 4'd8, 24'h43);
        chk_w("t5_last", 9, 4'd15, 24'h4A);
        chk("t5_err", 32'(o_err_count), 32'd1);
        chk("t5_ready_pend", 32'(s_ready), 32'd0);
        pulse_fe(); idle(1);
        chk("t5_bank", 32'(o_disp_bank), 32'd1);

        // 6: disable mid-frame abandons it
        do_reset(); i_enable = 1'b1; idle(1);
        for (int i = 0; i < 5; i++) beat(24'h51 + 24'(i), i == 0, i == 3, 1'b0);
        i_enable = 1'b0;
        idle(1);
        chk("t6_ready_off", 32'(s_ready), 32'd0);
        pulse_fe(); idle(1);
        chk("t6_done", 32'(done_cnt), 32'd0);
        chk("t6_bank", 32'(o_disp_bank), 32'd0);
        chk("t6_nwr", 32'(wa.size()), 32'd5);
        // then swap once, fill again and reset while the swap is pending
        i_enable = 1'b1; idle(1);
        frame(24'h000060, 1'b0);
        idle(1);
        pulse_fe(); idle(1);
        chk("t6_bank_sw", 32'(o_disp_bank), 32'd1);
        frame(24'h000070, 1'b0);
        idle(1);
        chk("t6_pend", 32'(s_ready), 32'd0);
        rst = 1'b1;
        idle(1);
        chk("t6_rst_bank", 32'(o_disp_bank), 32'd0);
        chk("t6_rst_ready", 32'(s_ready), 32'd0);
        chk("t6_rst_wr_en", 32'(o_wr_en), 32'd0);
        chk("t6_rst_addr", 32'(o_wr_addr), 32'd0);
        chk("t6_rst_data", 32'(o_wr_data), 32'd0);
        chk("t6_rst_done", 32'(o_frame_done), 32'd0);
        chk("t6_rst_err", 32'(o_err_count), 32'd0);
        rst = 1'b0;
        wa.delete(); wd.delete();
        idle(1);
        beat(24'h81, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk_w("t6_after_rst", 0, 4'd8, 24'h81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
